uart_instr_loader: RTL and testbench
====================================

Name: uart_instr_loader

Overview:
- Upstream loader for the instruction ROM: receives a program over a UART serial line (8N1, LSB first) and assembles byte pairs into 16-bit instruction words.
- Issues one-cycle write strobes with an incrementing address into the ROM write port.
- Reports load completion and the last written address. The user interface consumes these to gate CPU start and stepping.

Parameters:
- CLK_FREQ, 50000000, i_clk frequency in Hz.
- BAUD_RATE, 115200, serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, must be >= 4).
- ADDR_WIDTH, 8, ROM address width (256 words).
- DATA_WIDTH, 16, instruction word width. Fixed at two bytes.
- END_WORD, 16'hFFFF, terminator word. It ends the load and is never written.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_rx  input  1  asynchronous UART line, idles high.
- o_wr_en  output  1  one-cycle ROM write strobe.
- o_wr_addr  output  ADDR_WIDTH  ROM write address, valid while o_wr_en=1.
- o_wr_data  output  DATA_WIDTH  instruction word, valid while o_wr_en=1.
- o_instr_transmit_done  output  1  sticky; program load finished.
- o_max_addr  output  ADDR_WIDTH  address of the last written word (0 if none written).
- o_frame_err  output  1  sticky; at least one byte was discarded for a bad stop bit.

Behaviour:
- Reset (i_rst=1 at a clock edge) clears everything:
  - All outputs go to 0; the internal address counter goes to 0.
  - The byte-pair flag clears; the FSM returns to IDLE.
  - The synchronizer flops are set to 1.
  - Reset mid-frame or mid-word abandons the partial data silently.
- i_rx passes through a 2-flop synchronizer; rx_s is the second flop. This adds 2 cycles of latency before edge detection.
- Rx FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: when rx_s=0 is seen, load the baud counter and go to START.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s. If 0, go to DATA with bit index 0. If 1, treat as a glitch and return to IDLE with no output.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After bit 7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1, the byte is accepted; go to IDLE.
    - If 0, set o_frame_err, discard the byte, clear the byte-pair flag (drop any held high byte), and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This avoids false starts on a break condition.
- Word assembly:
  - The first accepted byte of a pair is the high byte [15:8]. It is held and the pair flag is set.
  - The second accepted byte is the low byte [7:0]. The pair flag clears.
- Word commit happens in the cycle after the low byte's stop-bit acceptance:
  - If word == END_WORD: no write. Set o_instr_transmit_done.
  - Otherwise: o_wr_en=1 for exactly one cycle, with o_wr_addr = counter and o_wr_data = word. In the same cycle, o_max_addr is set to the counter value. The counter increments on the following edge.
- Address wrap:
  - A write at address 2^ADDR_WIDTH-1 (255) also sets o_instr_transmit_done in the same commit.
  - The counter does not wrap; no further writes occur.
- Once done is set:
  - The receiver keeps framing bytes but commits nothing.
  - o_wr_en stays 0 and o_max_addr is frozen until reset.
- Empty program (first word is END_WORD): done=1, o_max_addr=0, no write.
- Odd trailing byte (high byte received, no low byte): held indefinitely, never written.
- Fixed latency: o_wr_en asserts 1 cycle after the low byte's stop-bit sample cycle.
- Counters: the baud counter is wide enough for CLKS_PER_BIT. The bit index is 3 bits.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD_RATE=1 (16 clocks per bit), ideal 8N1 frames.
1. Send bytes 0x12,0x34,0x56,0x78,0xFF,0xFF.
   -> Writes (addr 0, 0x1234) and (addr 1, 0x5678), each exactly one cycle wide.
   -> Then done=1, o_max_addr=1, frame_err=0.
2. Send 0xFF,0xFF first.
   -> No o_wr_en pulse; done=1; o_max_addr=0.
3. Send a 6-cycle low pulse on i_rx, then the frame pair 0xAB,0xCD.
   -> The glitch is rejected.
   -> Single write (addr 0, 0xABCD); frame_err=0.
4. Send 0x11 normally, then 0x22 with stop bit 0, then 0x33,0x44.
   -> frame_err=1.
   -> 0x11 is dropped; the only write is (addr 0, 0x3344).
5. Send 256 non-terminator words with data = address.
   -> 256 writes, with the last at addr 255.
   -> done=1 on that commit; o_max_addr=255.
   -> A 257th word produces no write.
6. Assert i_rst for 1 cycle during bit 4 of the second byte of word 1 (after word 0 was written), then send 0x00,0x01,0xFF,0xFF.
   -> All outputs return to 0.
   -> Next write is (addr 0, 0x0001); done=1; o_max_addr=0.

Source files
------------

// File: rtl/uart_instr_loader.sv
// UART (8N1, LSB first) program loader: pairs received bytes into 16-bit words
// and writes them to the instruction ROM with an incrementing address.
module uart_instr_loader #(
    parameter int unsigned            CLK_FREQ   = 50000000,
    parameter int unsigned            BAUD_RATE  = 115200,
    parameter int unsigned            ADDR_WIDTH = 8,
    parameter int unsigned            DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0]  END_WORD   = 16'hFFFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_instr_transmit_done,
    output logic [ADDR_WIDTH-1:0] o_max_addr,
    output logic                  o_frame_err
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitIdle
    } rx_state_e;

    logic                  rx_meta_q, rx_s_q;
    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      baud_cnt_q, baud_cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            hi_byte_q, hi_byte_d;
    logic                  pair_q, pair_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] max_addr_q, max_addr_d;
    logic                  frame_err_q, frame_err_d;
    logic                  byte_ok;
    logic                  baud_tick;
    logic [DATA_WIDTH-1:0] word;

    assign baud_tick = (baud_cnt_q == '0);
    assign word      = {hi_byte_q, shift_q};

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hi_byte_d   = hi_byte_q;
        pair_d      = pair_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = done_q;
        max_addr_d  = max_addr_q;
        frame_err_d = frame_err_q;
        byte_ok     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    baud_cnt_d = HALF_LD;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    // A start bit that is gone by mid-bit is a glitch.
                    if (!rx_s_q) begin
                        state_d    = StData;
                        bit_idx_d  = 3'd0;
                        baud_cnt_d = FULL_LD;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            StData: begin
                if (baud_tick) begin
                    shift_d    = {rx_s_q, shift_q[7:1]};
                    baud_cnt_d = FULL_LD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            StStop: begin
                if (baud_tick) begin
                    if (rx_s_q) begin
                        byte_ok = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        pair_d      = 1'b0;
                        state_d     = StWaitIdle;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 1'b1;
                end
            end
            StWaitIdle: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (byte_ok) begin
            if (!pair_q) begin
                hi_byte_d = shift_q;
                pair_d    = 1'b1;
            end else begin
                pair_d = 1'b0;
                if (!done_q) begin
                    if (word == END_WORD) begin
                        done_d = 1'b1;
                    end else begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = word;
                        max_addr_d = addr_q;
                        // Last ROM slot filled: the load is complete.
                        if (addr_q == '1) begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
        end

        if (wr_en_q && (addr_q != '1)) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= StIdle;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hi_byte_q   <= '0;
            pair_q      <= 1'b0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            max_addr_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= i_rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hi_byte_q   <= hi_byte_d;
            pair_q      <= pair_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            max_addr_q  <= max_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_wr_en               = wr_en_q;
    assign o_wr_addr             = wr_addr_q;
    assign o_wr_data             = wr_data_q;
    assign o_instr_transmit_done = done_q;
    assign o_max_addr            = max_addr_q;
    assign o_frame_err           = frame_err_q;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Scoreboard bench for uart_instr_loader: byte-level reference model pushes expected
// ROM writes; a negedge monitor pops and compares each write strobe.
module tb_uart_instr_loader;

    localparam int CPB = 16;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic        done;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_rx = 1'b1;
    logic        o_wr_en;
    logic [7:0]  o_wr_addr;
    logic [15:0] o_wr_data;
    logic        o_instr_transmit_done;
    logic [7:0]  o_max_addr;
    logic        o_frame_err;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic prev_wr_en = 1'b0;

    // Reference model state
    bit         m_have_hi;
    logic [7:0] m_hi;
    int         m_addr;
    int         m_max;
    bit         m_done;
    bit         m_ferr;

    always #5 clk = ~clk;

    uart_instr_loader #(
        .CLK_FREQ  (16),
        .BAUD_RATE (1),
        .ADDR_WIDTH(8),
        .DATA_WIDTH(16),
        .END_WORD  (16'hFFFF)
    ) dut (
        .i_clk                (clk),
        .i_rst                (i_rst),
        .i_rx                 (i_rx),
        .o_wr_en              (o_wr_en),
        .o_wr_addr            (o_wr_addr),
        .o_wr_data            (o_wr_data),
        .o_instr_transmit_done(o_instr_transmit_done),
        .o_max_addr           (o_max_addr),
        .o_frame_err          (o_frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_have_hi = 1'b0;
        m_hi      = 8'h00;
        m_addr    = 0;
        m_max     = 0;
        m_done    = 1'b0;
        m_ferr    = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        logic [15:0] w;
        exp_t e;
        if (!stop_ok) begin
            m_ferr    = 1'b1;
            m_have_hi = 1'b0;
        end else if (!m_have_hi) begin
            m_hi      = b;
            m_have_hi = 1'b1;
        end else begin
            m_have_hi = 1'b0;
            w = {m_hi, b};
            if (!m_done) begin
                if (w == 16'hFFFF) begin
                    m_done = 1'b1;
                end else begin
                    e.addr = 8'(m_addr);
                    e.data = w;
                    e.done = (m_addr == 255);
                    exp_q.push_back(e);
                    m_max = m_addr;
                    if (m_addr == 255) m_done = 1'b1;
                    else m_addr = m_addr + 1;
                end
            end
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        i_rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(stop_ok, CPB);
        if (!stop_ok) drive_bit(1'b1, CPB);
        i_rx = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, 32'(o_wr_en), 0);
        check({tag, "_wr_addr"}, 32'(o_wr_addr), 0);
        check({tag, "_wr_data"}, 32'(o_wr_data), 0);
        check({tag, "_done"}, 32'(o_instr_transmit_done), 0);
        check({tag, "_max_addr"}, 32'(o_max_addr), 0);
        check({tag, "_frame_err"}, 32'(o_frame_err), 0);
    endtask

    task automatic reset_dut(input string tag);
        @(negedge clk);
        i_rst = 1'b1;
        i_rx  = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        model_reset();
        check_outputs_zero(tag);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_end(input string tag);
        repeat (40) @(negedge clk);
        check({tag, "_done"}, 32'(o_instr_transmit_done), 32'(m_done));
        check({tag, "_max_addr"}, 32'(o_max_addr), 32'(m_max));
        check({tag, "_frame_err"}, 32'(o_frame_err), 32'(m_ferr));
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 0);
    endtask

    // Monitor: every strobe must match the oldest expected write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_wr_en === 1'b1) begin
                check("wr_pulse_width", 32'(prev_wr_en), 0);
                check("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(o_wr_addr), 32'(e.addr));
                    check("wr_data", 32'(o_wr_data), 32'(e.data));
                    check("wr_max_addr", 32'(o_max_addr), 32'(e.addr));
                    check("wr_done", 32'(o_instr_transmit_done), 32'(e.done));
                end
            end
            prev_wr_en = o_wr_en;
        end
    end

    initial begin
        repeat (99000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("por");
        i_rst = 1'b0;
        repeat (4) @(negedge clk);

        // Two words then terminator
        reset_dut("s1_rst");
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1); send_byte(8'h78, 1'b1);
        send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
        check_end("s1");

        // Empty program
        reset_dut("s2_rst");
        send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
        check_end("s2");

        // Short glitch on the line must be ignored
        reset_dut("s3_rst");
        drive_bit(1'b0, 6);
        drive_bit(1'b1, 30);
        send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
        check_end("s3");

        // Framing error drops the held high byte
        reset_dut("s4_rst");
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        check_end("s4");

        // Fill all 256 slots, then one extra word
        reset_dut("s5_rst");
        for (int a = 0; a < 256; a++) begin
            send_byte(8'h00, 1'b1);
            send_byte(8'(a), 1'b1);
        end
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        check_end("s5");

        // Reset in the middle of a word
        reset_dut("s6_rst");
        send_byte(8'h5A, 1'b1); send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, CPB);
        drive_bit(1'b0, CPB / 2);
        check("s6_pre_reset_pending", 32'(exp_q.size()), 0);
        check("s6_pre_reset_max", 32'(o_max_addr), 0);
        reset_dut("s6_mid_rst");
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
        check_end("s6");

        // Random words with occasional bad stop bits
        reset_dut("s7_rst");
        for (int k = 0; k < 5; k++) begin
            send_byte(8'($urandom), ($urandom_range(0, 7) != 0));
            send_byte(8'($urandom), ($urandom_range(0, 7) != 0));
        end
        send_byte(8'hFF, 1'b1); send_byte(8'hFF, 1'b1);
        check_end("s7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
